hd_unloader: RTL and testbench
==============================

# hd_unloader

Reads the final hard-decision codeword out of the two-bank hard-decision RAM once the decoder has finished and emits it as a packed, LSB-first word stream over a valid/ready interface. Bank 0 holds even bit indices and bank 1 holds odd bit indices, both at address `i>>1`, so each read cycle yields 2 bits. The top level gives this block the RAM ports while `busy`=1.

## Interface
- `ADDR_WIDTH`, 8: RAM address width per bank.
- `N_BITS`, 256: codeword length. Must be a multiple of `OUT_WIDTH` and ≤ 2·2^ADDR_WIDTH.
- `OUT_WIDTH`, 8: output word width. Even, ≥ 4.
- `clk`  in  1: clock. One clock domain; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to unload. Ignored while `busy`=1.
- `busy`  out  1: high from the cycle after `start` accepted until `done`, inclusive.
- `done`  out  1: one-cycle pulse after the last word handshake.
- `ram_address`  out  [1:0][ADDR_WIDTH] : per-bank read address.
- `ram_cs`  out  [1:0]: per-bank chip select. Both bits are always equal.
- `ram_we`  out  [1:0]: constant 0.
- `ram_data_out`  in  [1:0][1]: read data. Valid the cycle after `ram_cs`.
- `out_data`  out  OUT_WIDTH: packed bits. Bit index k maps to `out_data[k % OUT_WIDTH]`.
- `out_valid`  out  1: word valid.
- `out_ready`  in  1: sink accepts the word.
- `out_last`  out  1: high with the final word of the codeword.

## Operation
- FSM states:
  - **IDLE**: on `start`, clear the read address, the accumulator and the word counter, then go to READ.
  - **READ**: issue reads, accumulate bits and emit words. After the final read issues, go to DRAIN.
  - **DRAIN**: emit the remaining words. On the last word handshake, go to DONE.
  - **DONE**: pulse `done`, then return to IDLE.
- Read issue rule:
  - A read is issued (`ram_cs`=2'b11, both banks at address a) only if its 2 returned bits are guaranteed a slot in the accumulator next cycle.
  - At most one read is in flight.
  - a increments by 1 per issued read, from 0 to N_BITS/2−1. The address never wraps past the last read.
- Accumulator:
  - OUT_WIDTH bits plus a fill count.
  - Returned `ram_data_out[0]` goes to position fill and `[1]` to position fill+1; fill then increases by 2.
  - When fill reaches OUT_WIDTH, the word moves to the output register if that register is empty or is being drained in the same cycle. In that same cycle the accumulator can accept new bits starting at position 0.
- Output register:
  - Holds `out_data`/`out_valid`/`out_last` stable until `out_valid`&&`out_ready`.
  - `out_last` is set on word number N_BITS/OUT_WIDTH−1.
- No bit is lost, duplicated or reordered under any `out_ready` pattern.
- Word counter width is clog2(N_BITS/OUT_WIDTH)+1. Address counter width is ADDR_WIDTH+1, so the terminal compare does not overflow.

## Timing
- Reset values: `busy`, `done`, `out_valid`, `out_last` and `ram_cs` are 0; `out_data` and `ram_address` are 0; FSM is in IDLE.
- Reset asserted mid-unload aborts immediately with no `done`. The first `start` after release begins a fresh unload from bit 0.
- Key cycles, with `start` sampled high at cycle 0:
  - cycle 1: `busy`=1 and the first read is issued.
  - cycle 2: the first data returns.
- Throughput with `out_ready` held high:
  - One read per cycle with no bubbles.
  - The first `out_valid` appears at cycle OUT_WIDTH/2+2.
  - Subsequent words follow every OUT_WIDTH/2 cycles.
  - Total time from `start` to `done` is N_BITS/2+3 cycles.
- Under backpressure, reads stall (`ram_cs`=0) once both the accumulator and the output register are committed. Reads resume the cycle after the handshake frees space.
- `start` pulses while `busy`=1 have no effect. `start` in the same cycle as `done` is ignored. A new `start` is accepted from the cycle after `done`.

## Test plan
- **Basic unload** (N_BITS=16, OUT_WIDTH=8): RAM bit i = (i%3==0), i.e. bank0 = {1,0,0,1,0,0,1,0}, bank1 = {0,1,0,0,1,0,0,1}. `out_ready`=1, `start` at cycle 0 → words 0x49 then 0x92. `out_last` is high on 0x92. `done` pulses at cycle 11. `ram_we` is 0 throughout.
- **Throughput** (N_BITS=256, all ones, `out_ready`=1) → 32 words of 0xFF, one every 4 cycles, `ram_cs` high for 128 consecutive cycles, `done` at cycle 131.
- **Backpressure** (basic pattern, `out_ready` low for 10 cycles from the first `out_valid`) → `out_data`=0x49 held stable, reads stall, no overrun. After `out_ready` rises: 0x49, 0x92, `done`.
- **Random ready** (N_BITS=256, random bits, `out_ready` random at 50%) → the output stream equals the scoreboard order, with 32 words and exactly one `out_last`.
- **Start while busy**: a second `start` pulse mid-unload is ignored, with exactly 2 words for N_BITS=16. A `start` in the cycle after `done` begins a new identical unload.
- **Reset mid-op**: `reset` low during word 1 → all outputs 0 within the same cycle, no `done`. A `start` after release yields 0x49, 0x92 again.

Source files
------------

// File: rtl/hd_unloader_if.sv
// RAM read ports and packed output stream of the hard-decision unloader.
interface hd_unloader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 8
);
  logic [1:0][ADDR_WIDTH-1:0] ram_address;
  logic [1:0]                 ram_cs;
  logic [1:0]                 ram_we;
  logic [1:0]                 ram_data_out;
  logic [OUT_WIDTH-1:0]       out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  // Unloader side.
  modport master (
    output ram_address, ram_cs, ram_we, out_data, out_valid, out_last,
    input  ram_data_out, out_ready
  );

  // RAM and sink side.
  modport slave (
    input  ram_address, ram_cs, ram_we, out_data, out_valid, out_last,
    output ram_data_out, out_ready
  );
endinterface

// File: rtl/hd_unloader.sv
// Streams the two-bank hard-decision RAM out as packed LSB-first words.
// Bank 0 holds even bit indices, bank 1 odd ones, both at address i>>1.
module hd_unloader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned N_BITS     = 256,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  hd_unloader_if.master bus
);
  localparam int unsigned NumReads = N_BITS / 2;
  localparam int unsigned NumWords = N_BITS / OUT_WIDTH;
  localparam int unsigned WcntW    = $clog2(NumWords) + 1;
  localparam int unsigned FillW    = $clog2(OUT_WIDTH) + 1;

  localparam logic [ADDR_WIDTH:0] LastAddr   = (ADDR_WIDTH + 1)'(NumReads - 1);
  localparam logic [WcntW-1:0]    LastWord   = WcntW'(NumWords - 1);
  localparam logic [FillW-1:0]    FullFill   = FillW'(OUT_WIDTH);
  localparam logic [FillW-1:0]    AlmostFill = FillW'(OUT_WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    addr_q, addr_d;
  logic                   pend_q;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [FillW-1:0]       fill_q, fill_d, fill_sum;
  logic [WcntW-1:0]       wcnt_q, wcnt_d;
  logic [OUT_WIDTH-1:0]   odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic                   olast_q, olast_d;
  logic                   rd_ok, rd_issue, drain, load, word_full, clear;

  // A read may issue unless the word finishing this cycle would find the output register
  // still occupied; a same-cycle drain is deliberately not counted on.
  assign rd_ok = !(ovalid_q && (pend_q ? (fill_q == AlmostFill) : (fill_q == FullFill)));

  assign bus.ram_address = {2{addr_q[ADDR_WIDTH-1:0]}};
  assign bus.ram_cs      = {2{rd_issue}};
  assign bus.ram_we      = 2'b00;
  assign bus.out_data    = odata_q;
  assign bus.out_valid   = ovalid_q;
  assign bus.out_last    = olast_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: leave READ when the final read issues, DRAIN on the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (rd_issue && (addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (drain && olast_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    rd_issue = (state_q == StRead) && rd_ok;
  end

  // Datapath next state: merge returned bits, hand finished words to the output register.
  always_comb begin
    acc_d    = acc_q;
    fill_sum = fill_q;
    addr_d   = addr_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    wcnt_d   = wcnt_q;
    clear    = (state_q == StIdle) && start;

    if (pend_q) begin
      for (int k = 0; k < OUT_WIDTH; k += 2) begin
        if (fill_q == FillW'(k)) begin
          acc_d[k]   = bus.ram_data_out[0];
          acc_d[k+1] = bus.ram_data_out[1];
        end
      end
      fill_sum = fill_q + FillW'(2);
    end

    word_full = (fill_sum == FullFill);
    drain     = ovalid_q && bus.out_ready;
    load      = word_full && (!ovalid_q || drain);
    fill_d    = load ? '0 : fill_sum;

    if (drain) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end
    if (load) begin
      odata_d  = acc_d;
      ovalid_d = 1'b1;
      olast_d  = (wcnt_q == LastWord);
      wcnt_d   = wcnt_q + WcntW'(1);
    end

    // Address holds on the final read rather than wrapping.
    if (rd_issue && (addr_q != LastAddr)) addr_d = addr_q + (ADDR_WIDTH + 1)'(1);

    if (clear) begin
      addr_d = '0;
      acc_d  = '0;
      fill_d = '0;
      wcnt_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      pend_q   <= 1'b0;
      acc_q    <= '0;
      fill_q   <= '0;
      wcnt_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      pend_q   <= rd_issue;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      wcnt_q   <= wcnt_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end
endmodule

// File: tb/tb_hd_unloader.sv
// Two unloaders (16-bit and 256-bit codewords) checked against a word scoreboard built
// directly from the RAM image.
module tb_hd_unloader;
  localparam int AW = 8;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start[2];
  logic          ready[2];
  logic          busy[2];
  logic          done[2];
  logic [OW-1:0] o_data[2];
  logic          o_valid[2];
  logic          o_last[2];
  logic [1:0]    o_cs[2];
  logic [1:0]    o_we[2];
  logic [AW-1:0] o_addr0[2];
  logic [AW-1:0] o_addr1[2];
  logic          mem[2][256];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hd_unloader_if #(.ADDR_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

    hd_unloader #(
      .ADDR_WIDTH(AW),
      .N_BITS    (g == 0 ? 16 : 256),
      .OUT_WIDTH (OW)
    ) u_dut (
      .clk  (clk),
      .reset(rst_n),
      .start(start[g]),
      .busy (busy[g]),
      .done (done[g]),
      .bus  (bus)
    );

    assign bus.out_ready = ready[g];
    assign o_data[g]     = bus.out_data;
    assign o_valid[g]    = bus.out_valid;
    assign o_last[g]     = bus.out_last;
    assign o_cs[g]       = bus.ram_cs;
    assign o_we[g]       = bus.ram_we;
    assign o_addr0[g]    = bus.ram_address[0];
    assign o_addr1[g]    = bus.ram_address[1];

    // RAM: data one cycle after chip select, junk otherwise.
    always @(posedge clk) begin
      if (bus.ram_cs[0])
        bus.ram_data_out <= {mem[g][2*bus.ram_address[1]+1], mem[g][2*bus.ram_address[0]]};
      else
        bus.ram_data_out <= 2'($urandom);
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit            active[2];
  bit            fast[2];
  int            st_cyc[2];
  int            got[2];
  int            reads[2];
  int            last_hs[2];
  int            first_v[2];
  int            done_rel[2];
  int            lasts[2];
  logic [OW-1:0] exp_w[2][32];
  logic [OW-1:0] got_w[2][32];
  bit            hold_v[2];
  logic [OW-1:0] hold_d[2];
  logic          hold_l[2];

  function automatic int nb(input int i);
    return (i == 0) ? 16 : 256;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req,
               $time);
    end
  endtask

  // Scoreboard: word w is bits w*OW .. w*OW+OW-1 of the RAM image, LSB first.
  task automatic begin_unload(input int i, input bit f);
    for (int w = 0; w < nb(i) / OW; w++)
      for (int k = 0; k < OW; k++) exp_w[i][w][k] = mem[i][w*OW+k];
    active[i]   = 1'b1;
    fast[i]     = f;
    st_cyc[i]   = cyc;
    got[i]      = 0;
    reads[i]    = 0;
    last_hs[i]  = -1;
    first_v[i]  = -1;
    done_rel[i] = -1;
    lasts[i]    = 0;
    hold_v[i]   = 1'b0;
    start[i]    = 1'b1;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles from first valid.
  task automatic finish_unload(input int i, input int mode);
    int bp;
    bit seen;
    bp = 0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && active[i]; c++) begin
      @(posedge clk); #1;
      start[i] = 1'b0;
      if (mode == 1) ready[i] = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (o_valid[i] && !seen) seen = 1'b1;
        if (seen) begin
          if (bp >= 10) ready[i] = 1'b1;
          bp++;
        end
      end
    end
    if (active[i]) begin
      chk(1'b0, "timeout", got[i], nb(i) / OW);
      active[i] = 1'b0;
    end
  endtask

  task automatic run(input int i, input int mode, input bit f);
    @(posedge clk); #1;
    ready[i] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    begin_unload(i, f);
    finish_unload(i, mode);
  endtask

  // Per-cycle comparison against the scoreboard and the timing rules.
  always @(negedge clk) begin : mon
    int rel;
    int nw;
    bit hs;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rel = cyc - st_cyc[i];
        nw  = nb(i) / OW;
        chk(o_we[i] == 2'b00 && o_cs[i][0] == o_cs[i][1], "we_cs_form", {o_we[i], o_cs[i]},
            {2'b00, {2{o_cs[i][0]}}});
        if (!active[i]) begin
          chk(!busy[i] && !done[i] && !o_valid[i] && o_cs[i] == 2'b00, "idle_quiet",
              {busy[i], done[i], o_valid[i], o_cs[i]}, 0);
        end else begin
          hs = o_valid[i] && ready[i];
          if (o_cs[i][0]) reads[i]++;
          if (hold_v[i])
            chk(o_valid[i] && o_data[i] == hold_d[i] && o_last[i] == hold_l[i], "hold_stable",
                {o_valid[i], o_data[i]}, {1'b1, hold_d[i]});
          hold_v[i] = o_valid[i] && !ready[i];
          hold_d[i] = o_data[i];
          hold_l[i] = o_last[i];
          if (o_valid[i] && first_v[i] < 0) first_v[i] = rel;
          if (hs) begin
            if (got[i] < nw) begin
              chk(o_data[i] == exp_w[i][got[i]], "word", o_data[i], exp_w[i][got[i]]);
              chk(o_last[i] == (got[i] == nw - 1), "last_flag", o_last[i], got[i] == nw - 1);
              got_w[i][got[i]] = o_data[i];
            end else begin
              chk(1'b0, "extra_word", got[i], nw - 1);
            end
            if (o_last[i]) lasts[i]++;
            got[i]++;
            if (got[i] == nw) last_hs[i] = rel;
          end
          chk(reads[i] <= nb(i) / 2 && 2 * reads[i] - OW * got[i] <= 2 * OW, "read_window",
              2 * reads[i] - OW * got[i], 2 * OW);
          chk(busy[i] == (rel >= 1), "busy", busy[i], rel >= 1);
          chk(done[i] == (last_hs[i] >= 0 && rel == last_hs[i] + 1), "done_pulse", done[i],
              last_hs[i] >= 0 && rel == last_hs[i] + 1);
          if (fast[i])
            chk(o_cs[i] == ((rel >= 1 && rel <= nb(i) / 2) ? 2'b11 : 2'b00), "cs_stream",
                o_cs[i], (rel >= 1 && rel <= nb(i) / 2) ? 3 : 0);
          if (done[i]) begin
            done_rel[i] = rel;
            active[i]   = 1'b0;
            chk(got[i] == nw && lasts[i] == 1, "word_count", got[i], nw);
            chk(reads[i] == nb(i) / 2, "read_count", reads[i], nb(i) / 2);
            if (fast[i]) begin
              chk(first_v[i] == OW / 2 + 2, "first_valid_cycle", first_v[i], OW / 2 + 2);
              chk(rel == nb(i) / 2 + 3, "done_cycle", rel, nb(i) / 2 + 3);
            end
          end
        end
      end
    end
  end

  initial begin
    bit seen_done;
    for (int i = 0; i < 2; i++) begin
      start[i]  = 1'b0;
      ready[i]  = 1'b0;
      active[i] = 1'b0;
      fast[i]   = 1'b0;
      st_cyc[i] = 0;
    end
    for (int b = 0; b < 256; b++) begin
      mem[0][b] = (b % 3 == 0);
      mem[1][b] = 1'b1;
    end

    // Reset values.
    #3;
    for (int i = 0; i < 2; i++) begin
      chk(!busy[i] && !done[i] && !o_valid[i] && !o_last[i] && o_cs[i] == 2'b00,
          "reset_ctrl", {busy[i], done[i], o_valid[i], o_last[i], o_cs[i]}, 0);
      chk(o_data[i] == '0 && o_addr0[i] == '0 && o_addr1[i] == '0, "reset_data",
          {o_data[i], o_addr0[i], o_addr1[i]}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic unload, 16 bits of i%3==0.
    run(0, 0, 1'b1);
    chk(exp_w[0][0] == 8'h49 && exp_w[0][1] == 8'h92, "model_pin", {exp_w[0][0], exp_w[0][1]},
        16'h4992);
    chk(got_w[0][0] == 8'h49, "basic_w0", got_w[0][0], 8'h49);
    chk(got_w[0][1] == 8'h92, "basic_w1", got_w[0][1], 8'h92);
    chk(done_rel[0] == 11, "basic_done_at_11", done_rel[0], 11);

    // Throughput, 256 ones.
    run(1, 0, 1'b1);
    chk(done_rel[1] == 131, "tput_done_at_131", done_rel[1], 131);
    chk(got_w[1][0] == 8'hFF && got_w[1][31] == 8'hFF, "tput_words", got_w[1][31], 8'hFF);

    // Backpressure on the basic pattern.
    run(0, 2, 1'b0);
    chk(got_w[0][0] == 8'h49 && got_w[0][1] == 8'h92, "bp_words", {got_w[0][0], got_w[0][1]},
        16'h4992);
    chk(done_rel[0] == 18, "bp_done_at_18", done_rel[0], 18);

    // Random bits, random ready.
    for (int b = 0; b < 256; b++) mem[1][b] = 1'($urandom);
    run(1, 1, 1'b0);
    chk(got[1] == 32 && lasts[1] == 1, "random_count", got[1], 32);

    // Start while busy, start in the done cycle, start the cycle after done.
    @(posedge clk); #1;
    ready[0] = 1'b1;
    begin_unload(0, 1'b1);
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(posedge clk); #1;
      start[0] = (cyc - st_cyc[0] == 5);
      if (done[0]) seen_done = 1'b1;
    end
    chk(seen_done, "busy_start_done_seen", seen_done, 1);
    chk(got[0] == 2, "busy_start_words", got[0], 2);
    start[0] = 1'b1;
    @(posedge clk); #1;
    chk(!busy[0], "done_cycle_start_ignored", busy[0], 0);
    begin_unload(0, 1'b1);
    finish_unload(0, 0);
    chk(got_w[0][0] == 8'h49 && got_w[0][1] == 8'h92, "restart_words",
        {got_w[0][0], got_w[0][1]}, 16'h4992);

    // Reset during word 1.
    @(posedge clk); #1;
    begin_unload(0, 1'b1);
    repeat (8) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    active[0] = 1'b0;
    chk(!busy[0] && !done[0] && !o_valid[0] && !o_last[0] && o_cs[0] == 2'b00,
        "midreset_ctrl", {busy[0], done[0], o_valid[0], o_last[0], o_cs[0]}, 0);
    chk(o_data[0] == '0 && o_addr0[0] == '0 && o_addr1[0] == '0, "midreset_data",
        {o_data[0], o_addr0[0], o_addr1[0]}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run(0, 0, 1'b1);
    chk(got_w[0][0] == 8'h49 && got_w[0][1] == 8'h92, "post_reset_words",
        {got_w[0][0], got_w[0][1]}, 16'h4992);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
